// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// State enum, default widths, requester id type and its one-hot decode.
package ram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int NUM_REQ        = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef logic req_id_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter: round-robin on a last-grant pointer, or fixed
// priority to requester 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, rst, accept};

    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`else
    req_id_t last_q;
    req_id_t last_d;

    // Reset to requester 1 so requester 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single falling-edge-sampled RAM port.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    ram_cs,
    output logic                    ram_we,
    output logic                    ram_oe,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic [DATA_WIDTH-1:0]   ram_data_in,
    input  logic [DATA_WIDTH-1:0]   ram_data_out
);

    state_t                  state_q, state_d;
    req_id_t                 owner_q, owner_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              grant;
    logic                    accept;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready[owner_q]) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // req_ready is combinational, so it is gated by rst to drop immediately.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        case (state_q)
            ST_IDLE:  if (!rst) req_ready = grant;
            ST_ISSUE: begin
                ram_cs = 1'b1;
                ram_we = we_q;
                ram_oe = ~we_q;
            end
            ST_RESP:  rsp_valid = id_onehot(owner_q);
            default:  ;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            owner_d = grant[1];
            we_d    = grant[1] ? req_we[1] : req_we[0];
            addr_d  = grant[1] ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                               : req_addr[0 +: ADDR_WIDTH];
            wdata_d = grant[1] ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                               : req_wdata[0 +: DATA_WIDTH];
        end
        if (state_q == ST_ISSUE && !we_q) begin
            rdata_d = ram_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter with a falling-edge RAM
// model and a transaction-level reference (shadow memory, grant rule).
module tb_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid, rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_cs, ram_we, ram_oe;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_data_in;
    logic [DW-1:0]   ram_data_out = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_oe       (ram_oe),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // RAM: samples on the falling edge
    logic [DW-1:0] ram_mem [256];
    always @(negedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data_in;
        if (ram_cs && ram_oe) ram_data_out <= ram_mem[ram_address];
    end

    // Reference state
    logic [DW-1:0] ref_mem [256];
    int            last_win;
    logic [DW-1:0] exp_rdata;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (FIXED) return 0;
        return (last_win == 0) ? 1 : 0;
    endfunction

    task automatic txn(input logic [1:0] v, input logic [1:0] post_v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int stall);
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          wop;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        rsp_ready = 2'b00;
        #1;
        w   = pick(v);
        a   = (w == 1) ? a1 : a0;
        d   = (w == 1) ? d1 : d0;
        wop = we[w];
        chk("idle_req_ready", {30'd0, req_ready}, (w == 1) ? 32'd2 : 32'd1);
        chk("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        tick();
        last_win = w;
        if (wop) ref_mem[a] = d;
        else     exp_rdata  = ref_mem[a];
        req_valid = post_v;
        #1;
        chk("issue_cs", {31'd0, ram_cs}, 32'd1);
        chk("issue_we", {31'd0, ram_we}, {31'd0, wop});
        chk("issue_oe", {31'd0, ram_oe}, {31'd0, ~wop});
        chk("issue_addr", {24'd0, ram_address}, {24'd0, a});
        if (wop) chk("issue_wdata", {16'd0, ram_data_in}, {16'd0, d});
        chk("issue_req_ready", {30'd0, req_ready}, 32'd0);
        chk("issue_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        tick();
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) rsp_ready = 2'b11;
            chk("resp_rsp_valid", {30'd0, rsp_valid}, (w == 1) ? 32'd2 : 32'd1);
            chk("resp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
            chk("resp_req_ready", {30'd0, req_ready}, 32'd0);
            chk("resp_cs", {31'd0, ram_cs}, 32'd0);
            tick();
        end
        chk("done_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0]    v, pv, we;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;
        int            st;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = DW'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        last_win  = 1;
        exp_rdata = '0;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b00;
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_addr", {24'd0, ram_address}, 32'd0);
        chk("rst_wdata", {16'd0, ram_data_in}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Write then read back from requester 0
        txn(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 16'hBEEF, 16'h0000, 0);
        txn(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0000, 16'h0000, 0);
        chk("beef_readback", {16'd0, rsp_rdata}, 32'h0000BEEF);

        // Continuous contention: alternate (round-robin) or all to 0 (fixed)
        for (int i = 0; i < 4; i++)
            txn(2'b11, 2'b11, 2'b00, 8'h20, 8'h21, 16'h0, 16'h0, 0);

        // Long response stall on requester 1 while requester 0 waits
        txn(2'b10, 2'b11, 2'b00, 8'h30, 8'h10, 16'h0, 16'h0, 5);
        txn(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0, 16'h0, 0);

        // Extreme data at extreme addresses
        txn(2'b01, 2'b00, 2'b01, 8'h00, 8'h00, 16'h0000, 16'h0, 0);
        txn(2'b10, 2'b00, 2'b10, 8'h00, 8'hFF, 16'h0, 16'hFFFF, 0);
        txn(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0);
        chk("addr00_data", {16'd0, rsp_rdata}, 32'h00000000);
        txn(2'b10, 2'b00, 2'b00, 8'h00, 8'hFF, 16'h0, 16'h0, 0);
        chk("addrFF_data", {16'd0, rsp_rdata}, 32'h0000FFFF);

        // Reset during ISSUE of a write aborts it
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {8'h00, 8'h44};
        req_wdata = {16'h0, 16'h1234};
        rsp_ready = 2'b11;
        tick();
        chk("abort_issue_cs", {31'd0, ram_cs}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cs_drop", {31'd0, ram_cs}, 32'd0);
        chk("abort_we_drop", {31'd0, ram_we}, 32'd0);
        chk("abort_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        last_win  = 1;
        exp_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_rsp", {30'd0, rsp_valid}, 32'd0);
            chk("abort_no_cs", {31'd0, ram_cs}, 32'd0);
            tick();
        end
        txn(2'b11, 2'b00, 2'b00, 8'h44, 8'h44, 16'h0, 16'h0, 0);

        // Randomized traffic against the reference
        for (int i = 0; i < 40; i++) begin
            v   = 2'($urandom_range(1, 3));
            pv  = 2'($urandom);
            we  = 2'($urandom);
            ra0 = AW'($urandom_range(0, 15));
            ra1 = AW'($urandom_range(0, 15));
            rd0 = DW'($urandom);
            rd1 = DW'($urandom);
            st  = $urandom_range(0, 3);
            txn(v, pv, we, ra0, ra1, rd0, rd1, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of RAM data words.
REQ-002 Parameter: ADDR_WIDTH, 8, width of RAM address.
REQ-003 Port: clk  input  1  single clock; all logic in this block on rising edge; the RAM samples on falling edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  2  per-requester request valid; requester i uses bit i.
REQ-006 Port: req_ready  output  2  per-requester request accept.
REQ-007 Port: req_we  input  2  per-requester op: 1 = write, 0 = read.
REQ-008 Port: req_addr  input  2*ADDR_WIDTH  requester i address at slice i.
REQ-009 Port: req_wdata  input  2*DATA_WIDTH  requester i write data at slice i.
REQ-010 Port: rsp_valid  output  2  per-requester completion valid.
REQ-011 Port: rsp_ready  input  2  per-requester completion accept.
REQ-012 Port: rsp_rdata  output  DATA_WIDTH  read data, shared, meaningful only with rsp_valid of a read.
REQ-013 Ports: ram_cs, ram_we, ram_oe  output  1 each  RAM chip select, write enable, output enable.
REQ-014 Ports: ram_address  output  ADDR_WIDTH; ram_data_in  output  DATA_WIDTH; ram_data_out  input  DATA_WIDTH.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, ISSUE, RESP.
REQ-016 In IDLE, req_ready SHALL be combinationally asserted only for the arbitration winner among asserted req_valid bits; all-zero when no request.
REQ-017 An accept (req_valid[i] & req_ready[i]) SHALL latch op, address, data and owner id, and move IDLE -> ISSUE.
REQ-018 In ISSUE, ram_cs SHALL be 1; ram_we = 1 and ram_oe = 0 for writes; ram_we = 0 and ram_oe = 1 for reads; address and data from the latched request.
REQ-019 At the rising edge ending ISSUE, the block SHALL capture ram_data_out into rsp_rdata (reads only), deassert all ram_* controls, and move to RESP.
REQ-020 In RESP, rsp_valid[owner] SHALL be 1 (writes and reads alike); on rsp_ready[owner] the FSM SHALL return to IDLE.
REQ-021 rsp_ready low SHALL stall in RESP indefinitely with rsp_valid and rsp_rdata held stable; no new grant during stall.
REQ-022 Latency: accept edge to rsp_valid = 2 cycles; minimum spacing between accepts = 3 cycles.
REQ-023 Default arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; a lone requester always wins.
REQ-024 Round-robin pointer SHALL update only on accept.
REQ-025 ram_* controls SHALL be 0 outside ISSUE; ram_address and ram_data_in hold last values.
REQ-026 req_valid dropped before accept SHALL have no effect; requests are not queued.

Reset
REQ-027 rst SHALL asynchronously force IDLE, req_ready/rsp_valid/ram_cs/ram_we/ram_oe = 0, rsp_rdata/ram_address/ram_data_in = 0, round-robin last-grant = requester 1 (requester 0 first).
REQ-028 Reset mid-ISSUE or mid-RESP SHALL abort the operation; no response issued after reset release.

Configuration
REQ-029 Macro RAM_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and the round-robin pointer is omitted; when undefined, REQ-023/024 apply.

Structure
REQ-030 Package ram_arb_pkg SHALL hold the FSM state enum, default DATA_WIDTH/ADDR_WIDTH constants, and the requester-id type.
REQ-031 Grant logic SHALL be a sub-module rr_arb2 (2-way arbiter with pointer, fixed-priority under the macro).

Verification
REQ-032 Req0 write addr 0x10 data 0xBEEF, then req0 read 0x10 -> ram_cs/ram_we high one cycle; read rsp_rdata = 0xBEEF, rsp_valid[0] 2 cycles after accept.
REQ-033 Both requesters valid continuously, reads -> grants alternate 0,1,0,1 (macro off); all grants to 0 (macro on).
REQ-034 Req1 read with rsp_ready[1] low 5 cycles -> rsp_valid[1] and rsp_rdata stable 5 cycles; req0 not granted until handshake.
REQ-035 rst asserted during ISSUE of a write -> ram_cs drops immediately; no rsp_valid after release; next request granted to requester 0.
REQ-036 Writes 0x0000 to addr 0x00 and 0xFFFF to addr 0xFF, read both back -> data exact, no address aliasing.
